// File: rtl/codificador_7seg.sv
// Seven-segment bus monitor: debounces the multiplexed anode/segment lines,
// decodes each stable pattern to BCD/blank/error and hands out 4-digit frames.
module codificador_7seg #(
    parameter int ESTAVEL = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [0:6]  segmentos,
    output logic [15:0] digitos,
    output logic [3:0]  erro,
    output logic        valido,
    input  logic        pronto,
    output logic        perdido
);

    localparam logic [7:0] EST = 8'(ESTAVEL);

    typedef enum logic {ESPERA, AMOSTRADO} estado_t;

    typedef struct packed {
        logic [3:0] an;
        logic [0:6] seg;
    } amostra_t;

    localparam amostra_t AMOSTRA_RST = '{an: 4'hF, seg: 7'h7F};

    amostra_t        r1_q, r2_q;
    logic [7:0]      cnt_q, cnt_d;
    estado_t         estado_q, estado_d;
    logic [3:0][3:0] slot_q;
    logic [3:0]      slot_err_q;
    logic [3:0]      mask_q, mask_d;
    logic [15:0]     digitos_q;
    logic [3:0]      erro_q;
    logic            valido_q, valido_d;
    logic            perdido_q;

    logic            igual;
    logic            captura;
    logic            an_ok;
    logic [1:0]      idx;
    logic [3:0]      cod;
    logic            cod_err;
    logic            frame_cheio;
    logic            carrega;

    assign igual   = (r1_q == r2_q);
    assign captura = igual && (cnt_q == EST - 8'd1) && (estado_q == ESPERA);

    always_comb begin
        cnt_d    = cnt_q;
        estado_d = estado_q;
        if (!igual) begin
            cnt_d    = 8'd0;
            estado_d = ESPERA;
        end else begin
            if (cnt_q < EST)
                cnt_d = cnt_q + 8'd1;
            if (captura)
                estado_d = AMOSTRADO;
        end
    end

    // Only a single low strobe identifies a digit; idle or overlapping strobes are skipped.
    always_comb begin
        an_ok = 1'b1;
        idx   = 2'd0;
        case (r1_q.an)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: an_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (r1_q.seg)
            7'b0000001: cod = 4'd0;
            7'b1001111: cod = 4'd1;
            7'b0010010: cod = 4'd2;
            7'b0000110: cod = 4'd3;
            7'b1001100: cod = 4'd4;
            7'b0100100: cod = 4'd5;
            7'b0100000: cod = 4'd6;
            7'b0001111: cod = 4'd7;
            7'b0000000: cod = 4'd8;
            7'b0000100: cod = 4'd9;
            7'b1111111: cod = 4'hF;
            default:    cod = 4'hE;
        endcase
        cod_err = (cod == 4'hE);
    end

    assign frame_cheio = (mask_q == 4'hF);
    assign carrega     = frame_cheio && (!valido_q || pronto);

    // The completed mask is cleared before this edge's capture is merged, so a
    // capture on the load edge starts the next frame.
    always_comb begin
        mask_d = frame_cheio ? 4'h0 : mask_q;
        if (captura && an_ok)
            mask_d[idx] = 1'b1;
    end

    always_comb begin
        valido_d = valido_q;
        if (carrega)
            valido_d = 1'b1;
        else if (valido_q && pronto)
            valido_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_q       <= AMOSTRA_RST;
            r2_q       <= AMOSTRA_RST;
            cnt_q      <= 8'd0;
            estado_q   <= ESPERA;
            slot_q     <= '0;
            slot_err_q <= '0;
            mask_q     <= '0;
            digitos_q  <= '0;
            erro_q     <= '0;
            valido_q   <= 1'b0;
            perdido_q  <= 1'b0;
        end else begin
            r1_q     <= {an, segmentos};
            r2_q     <= r1_q;
            cnt_q    <= cnt_d;
            estado_q <= estado_d;
            mask_q   <= mask_d;
            valido_q <= valido_d;
            if (captura && an_ok) begin
                slot_q[idx]     <= cod;
                slot_err_q[idx] <= cod_err;
            end
            if (carrega) begin
                digitos_q <= slot_q;
                erro_q    <= slot_err_q;
            end
            if (frame_cheio && valido_q && !pronto)
                perdido_q <= 1'b1;
        end
    end

    assign digitos = digitos_q;
    assign erro    = erro_q;
    assign valido  = valido_q;
    assign perdido = perdido_q;

endmodule
